rev_counter_n: RTL

- Parametrised successor to the single-width reversible counter.
- Integrates the prescaler, so it runs directly on the board `clk` without a separate slow clock.
- Counts in hex or BCD with N nibble digits, supports synchronous load, and selects wrap or saturate at the boundaries.
- Drives the 7-seg display path (`cnt`) and an LED carry indicator (`Rc`).

---
 rtl/rev_counter_n.sv | 117 +++++++++++
 1 files changed

// File: rtl/rev_counter_n.sv
// Reversible N-digit hex/BCD counter with integrated prescaler, load,
// and wrap/saturate boundary handling. All outputs are registered.
module rev_counter_n #(
    parameter int DIGITS   = 4,
    parameter int BCD      = 0,
    parameter int DIV      = 10_000_000,
    parameter int DIV_BITS = 24,
    localparam int W       = 4 * DIGITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         s,
    input  logic         sat,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [W-1:0] cnt,
    output logic         Rc,
    output logic         tick
);

    localparam logic [W-1:0]        MAX  = (BCD != 0) ? {DIGITS{4'h9}} : {W{1'b1}};
    localparam logic [DIV_BITS-1:0] TERM = DIV_BITS'(DIV - 1);

    logic [DIV_BITS-1:0] presc;
    logic                terminal;
    logic                at_bound;
    logic [W-1:0]        stepped;

    // Only ever called below MAX, so the top digit never overflows.
    function automatic logic [W-1:0] inc_val(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        if (BCD == 0) return v + W'(1);
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] dec_val(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        if (BCD == 0) return v - W'(1);
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Keeps the BCD invariant: a loaded digit above 9 becomes 9.
    function automatic logic [W-1:0] clamp_val(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        if (BCD != 0) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every signal gets a value on every path through this block,
        // otherwise synthesis infers a latch to hold the old value.
        terminal = en && (presc == TERM);
        at_bound = s ? (cnt == '0) : (cnt == MAX);
        stepped  = s ? dec_val(cnt) : inc_val(cnt);
        if (at_bound) begin
            stepped = sat ? cnt : (s ? MAX : '0);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            cnt   <= '0;
            presc <= '0;
            Rc    <= 1'b0;
            tick  <= 1'b0;
        end else if (load) begin
            cnt   <= clamp_val(din);
            presc <= '0;
            Rc    <= 1'b0;
            tick  <= 1'b0;
        end else begin
            tick <= terminal;
            Rc   <= terminal && at_bound;
            if (terminal) begin
                presc <= '0;
                cnt   <= stepped;
            end else if (en) begin
                presc <= presc + DIV_BITS'(1);
            end
        end
    end

endmodule
